// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction-fetch front end:
// datapath widths, the EBREAK encoding and the queue entry layout.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;

    localparam logic [INSTR_W-1:0] EBREAK = 32'h0010_0073;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Circular prefetch queue of {pc, instr} entries with a single-cycle flush.
// The head reads as all zeros while the queue is empty. The writer must never
// push into a full queue; the fetch front end guarantees that by construction.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           pushData_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && !flush_i;

    // Entry storage: written at the tail, no reset needed since count guards reads.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rdPtr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: issues sequential word fetches, tags in-order
// responses with their PC, buffers them in ifetch_queue and discards all
// queued and in-flight work on a redirect.
// Optional feature macro: IFETCH_PERF_EN adds four wrapping performance
// counters (accepted requests, redirects, discarded responses, starved cycles).
module ifetch_prefetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetchPc_q, fetchPc_d;
    logic [XLEN-1:0]  enqPc_q, enqPc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
    logic [CNT_W-1:0] queueCount;
    logic [CNT_W-1:0] rspInc;
    logic             reqFire;
    logic             rspDrop;
    logic             rspKeep;
    fetch_entry_t     rspEntry;
    fetch_entry_t     headEntry;

    // Counting queued plus in-flight words against DEPTH reserves a slot for
    // every outstanding request, so a response can never find the queue full.
    assign req_valid = !redirect_valid
                       && (int'(outstanding_q) < MAX_OUT)
                       && ((int'(queueCount) + int'(outstanding_q)) < DEPTH);
    assign req_addr  = fetchPc_q;
    assign reqFire   = req_valid && req_ready;

    assign rspInc   = {{(CNT_W-1){1'b0}}, rsp_valid};
    assign rspDrop  = rsp_valid && ((dropCnt_q != '0) || redirect_valid);
    assign rspKeep  = rsp_valid && !rspDrop;
    assign rspEntry = '{pc: enqPc_q, instr: rsp_data};

    ifetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (redirect_valid),
        .push_i    (rspKeep),
        .pushData_i(rspEntry),
        .pop_i     (instr_ready),
        .head_o    (headEntry),
        .count_o   (queueCount)
    );

    assign instr_valid = (queueCount != '0);
    assign instr       = headEntry.instr;
    assign pc_out      = headEntry.pc;

    // Next-state for fetch/enqueue PCs and in-flight bookkeeping; redirect overrides all.
    always_comb begin
        fetchPc_d     = fetchPc_q;
        enqPc_d       = enqPc_q;
        outstanding_d = outstanding_q + {{(CNT_W-1){1'b0}}, reqFire} - rspInc;
        dropCnt_d     = dropCnt_q;
        if (reqFire) begin
            fetchPc_d = fetchPc_q + 32'd4;
        end
        if (rspKeep) begin
            enqPc_d = enqPc_q + 32'd4;
        end
        if (rsp_valid && (dropCnt_q != '0)) begin
            dropCnt_d = dropCnt_q - 1'b1;
        end
        if (redirect_valid) begin
            fetchPc_d = alignWord(redirect_pc);
            enqPc_d   = alignWord(redirect_pc);
            dropCnt_d = outstanding_q - rspInc;
        end
    end

    // State registers; reset abandons any in-flight requests without tracking them.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc_q     <= RESET_PC;
            enqPc_q       <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            enqPc_q       <= enqPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perfFetch_q, perfFlush_q, perfDrop_q, perfStall_q;

    // Free-running event counters that simply wrap on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            perfFetch_q <= '0;
            perfFlush_q <= '0;
            perfDrop_q  <= '0;
            perfStall_q <= '0;
        end else begin
            perfFetch_q <= perfFetch_q + {31'd0, reqFire};
            perfFlush_q <= perfFlush_q + {31'd0, redirect_valid};
            perfDrop_q  <= perfDrop_q + {31'd0, rspDrop};
            perfStall_q <= perfStall_q + {31'd0, (instr_ready && !instr_valid)};
        end
    end

    assign perf_fetch_cnt = perfFetch_q;
    assign perf_flush_cnt = perfFlush_q;
    assign perf_drop_cnt  = perfDrop_q;
    assign perf_stall_cnt = perfStall_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch (DEPTH 4, MAX_OUT 2, RESET_PC 0).
// A behavioural memory answers each accepted fetch after a programmable
// latency with addr ^ 32'hA5A5_0000; expected instructions are queued when
// a request is accepted and compared when the core side dequeues them.
module tb_ifetch_prefetch;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

    ifetch_prefetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (4),
        .MAX_OUT (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .pc_out        (pc_out)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_drop_cnt (perf_drop_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } expInstr_t;

    typedef struct {
        logic        rqr;
        logic        ird;
        logic        expReqValid;
        logic [31:0] expReqAddr;
        logic        expInstrValid;
        logic [31:0] expPc;
    } vec_t;

    memReq_t     memQ[$];
    expInstr_t   sbQ[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          memLat;
    int          fireCnt;
    int          stallCnt;
    logic [31:0] expFetch;
    logic        found;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and memory bookkeeping for the cycle currently on the pins.
    task automatic observe();
        expInstr_t e;
        if (instr_valid && instr_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL deq unexpected: got pc %h expected no instruction (cycle %0d)", pc_out, cyc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("deq pc", pc_out, e.pc);
                checkOutput("deq instr", instr, e.instr);
            end
        end
        if (instr_ready && !instr_valid) stallCnt++;
        if (redirect_valid) begin
            checkOutput("req_valid during redirect", {31'd0, req_valid}, 32'd0);
            sbQ.delete();
            expFetch = {redirect_pc[31:2], 2'b00};
        end else if (req_valid && req_ready) begin
            checkOutput("req_addr", req_addr, expFetch);
            memQ.push_back('{addr: req_addr, due: cyc + memLat});
            sbQ.push_back('{pc: expFetch, instr: expFetch ^ K});
            expFetch = expFetch + 32'd4;
            fireCnt++;
        end
    endtask

    // One clock cycle: drive inputs after the edge, then observe mid-cycle.
    task automatic applyStimulus(input logic rdv, input logic [31:0] rpc, input logic ird, input logic rqr);
        @(posedge clk);
        #1;
        cyc++;
        reset          = 1'b0;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        instr_ready    = ird;
        req_ready      = rqr;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = memQ[0].addr ^ K;
            void'(memQ.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        @(negedge clk);
        observe();
    endtask

    task automatic resetDut(input int lat);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        memQ.delete();
        sbQ.delete();
        expFetch = 32'h0;
        memLat   = lat;
        cyc      = -1;
        fireCnt  = 0;
        stallCnt = 0;
        repeat (3) @(posedge clk);
    endtask

    // Bounded search for the first instruction after a redirect.
    task automatic expectFirstPc(input logic [31:0] pc);
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            if (instr_valid) begin
                found = 1'b1;
                checkOutput("first pc after redirect", pc_out, pc);
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL first pc after redirect: got no instruction expected pc %h", pc);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // rqr, ird, expReqValid, expReqAddr, expInstrValid, expPc
        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};

        $display("[TB] reset state, stalled request and streaming fetch");
        resetDut(1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, vecs[i].ird, vecs[i].rqr);
            checkOutput($sformatf("vec%0d req_valid", i), {31'd0, req_valid}, {31'd0, vecs[i].expReqValid});
            checkOutput($sformatf("vec%0d req_addr", i), req_addr, vecs[i].expReqAddr);
            checkOutput($sformatf("vec%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].expInstrValid});
            checkOutput($sformatf("vec%0d pc_out", i), pc_out,
                        vecs[i].expInstrValid ? vecs[i].expPc : 32'h0);
            checkOutput($sformatf("vec%0d instr", i), instr,
                        vecs[i].expInstrValid ? (vecs[i].expPc ^ K) : 32'h0);
        end

        $display("[TB] consumer stall fills the queue, release drains without bubbles");
        resetDut(1);
        repeat (20) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("stall fetch count", fireCnt, 32'd4);
        checkOutput("stall req_valid", {31'd0, req_valid}, 32'd0);
        checkOutput("stall instr_valid", {31'd0, instr_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            checkOutput($sformatf("drain%0d instr_valid", i), {31'd0, instr_valid}, 32'd1);
            checkOutput($sformatf("drain%0d pc_out", i), pc_out, 32'(i * 4));
        end

        $display("[TB] redirect with two queued and two in flight");
        resetDut(3);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("instr_valid after redirect", {31'd0, instr_valid}, 32'd0);
        expectFirstPc(32'h100);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] redirect coincident with response and dequeue");
        resetDut(3);
        repeat (7) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        checkOutput("coincident instr_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("coincident pc_out", pc_out, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("post-redirect instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("post-redirect req_valid", {31'd0, req_valid}, 32'd1);
        checkOutput("post-redirect req_addr", req_addr, 32'h200);
        expectFirstPc(32'h200);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] redirect to unaligned top of address space wraps");
        resetDut(1);
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap req_valid", {31'd0, req_valid}, 32'd1);
        checkOutput("wrap req_addr 0", req_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap req_addr 1", req_addr, 32'h0000_0000);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap first pc", pc_out, 32'hFFFF_FFFC);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

`ifdef IFETCH_PERF_EN
        $display("[TB] performance counters over two redirects");
        resetDut(3);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("perf_flush_cnt", perf_flush_cnt, 32'd2);
        checkOutput("perf_drop_cnt", perf_drop_cnt, 32'd3);
        checkOutput("perf_fetch_cnt", perf_fetch_cnt, fireCnt);
        checkOutput("perf_stall_cnt", perf_stall_cnt, stallCnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
